ram_req_ctrl: RTL

//  Request sequencer directly upstream of the synchronous single-port 32-bit RAM.
//  - Accepts read/write requests on a valid/ready interface and drives the RAM addr/dataIn/wrEnable pins.
//  - Absorbs the RAM's 1-cycle registered read latency; returns read data on a valid/ready response port.
//  - Implements byte-enabled writes by read-modify-write, since the RAM has only a whole-word write.

---
 rtl/ram_req_ctrl_pkg.sv | 21 ++
 rtl/ram_req_ctrl_be_merge.sv | 18 +
 rtl/ram_req_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and widths for the RAM request sequencer and its byte-merge helper.
package ram_req_ctrl_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_RMW_RD  = 3'd4,
    ST_RMW_CAP = 3'd5,
    ST_RMW_WR  = 3'd6
  } state_e;

  function automatic logic be_is_full(input logic [BE_W-1:0] be);
    return &be;
  endfunction

endpackage

// File: rtl/ram_req_ctrl_be_merge.sv
// Byte-lane merge: each enabled lane takes the new byte, the others keep the old one.
module ram_req_ctrl_be_merge
  import ram_req_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Sequences single-outstanding read/write requests onto a synchronous single-port RAM,
// hiding its one-cycle read latency and turning partial writes into read-modify-write.
module ram_req_ctrl
  import ram_req_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [BE_W-1:0]      req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [BUS_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_dataIn,
  output logic                 ram_wrEnable,
  input  logic [DATA_W-1:0]    ram_dataOut
);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0]    merged;
  logic                 accept;

  // Held low during reset even though the state decode alone would read as IDLE.
  assign req_ready = rst_n && (state_q == ST_IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;

  ram_req_ctrl_be_merge u_be_merge (
    .old_word (ram_dataOut),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!req_we) begin
            addr_d  = req_addr;
            state_d = ST_RD;
          end else if (be_is_full(req_be)) begin
            addr_d  = req_addr;
            din_d   = req_wdata;
            we_d    = 1'b1;
            state_d = ST_WR;
          end else if (req_be != '0) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD:      state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rsp_rdata_d = ram_dataOut;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RMW_RD:  state_d = ST_RMW_CAP;
      // RAM dataOut is valid here, so the merged word is staged for the write cycle.
      ST_RMW_CAP: begin
        din_d   = merged;
        we_d    = 1'b1;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_addr     = addr_q;
  assign ram_dataIn   = din_q;
  assign ram_wrEnable = we_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;

endmodule
